systolic_result_drain: RTL
==========================

# systolic_result_drain

Reads the final sums out of a row of `N` 8-bit accumulators at the bottom of the systolic array and streams them out one lane per beat over a valid/ready interface. On a `done` pulse it snapshots all accumulator outputs at once, so the array can continue independently. After the last beat it issues a one-cycle `acc_clear` pulse back to the accumulators, which starts the next accumulation window.

## Interface
- `N`, default 4: number of accumulator lanes drained, ≥2.
- `W`, default 8: width of each accumulator value.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `clear`  in  1  reset, asynchronous, active-high.
- `done`  in  1  single-cycle pulse: accumulation finished, sample `acc_bus`.
- `acc_bus`  in  N*W  concatenated accumulator outputs; lane k at bits [k*W+W-1 : k*W].
- `out_data`  out  W  value of the current lane.
- `out_idx`  out  max(1,ceil(log2 N))  lane number of `out_data`.
- `out_valid`  out  1  `out_data`/`out_idx` are valid.
- `out_ready`  in  1  consumer accepts the beat.
- `acc_clear`  out  1  one-cycle clear pulse to the accumulators.
- `busy`  out  1  high in any state other than IDLE.
- `overrun`  out  1  sticky flag: `done` arrived while the block was busy.

## Operation
- States: IDLE, SEND, CLR.
- IDLE:
  - `done`=1 → latch all N lanes of `acc_bus` into an internal buffer; set idx=0; go to SEND.
- SEND:
  - `out_valid`=1, `out_data`=buf[idx], `out_idx`=idx.
  - Beat = `out_valid` && `out_ready` at the clock edge.
  - On a beat with idx<N-1: idx+1.
  - On a beat with idx==N-1: go to CLR.
  - With no beat, all outputs hold.
- CLR:
  - `acc_clear`=1 for exactly one cycle, then go to IDLE.
- `done` while in SEND or CLR: the pulse is ignored; buffer and sequence are unchanged; `overrun` is set to 1.
  - `overrun` clears only on reset.
- The buffer is written only on an accepted `done` in IDLE. Later changes to `acc_bus` do not affect the values in flight.
- Values pass through unmodified; no arithmetic is done on the data.
- All outputs are registered.

## Timing
- Reset (asynchronous): state=IDLE, idx=0, buffer=0, `out_data`=0, `out_idx`=0, `out_valid`=0, `acc_clear`=0, `busy`=0, `overrun`=0.
- Reset asserted mid-drain aborts the drain immediately. Beats not yet delivered are lost, and no `acc_clear` is issued.
- Latency from `done` to the first beat:
  - `done` sampled at edge E.
  - `out_valid`=1 with lane 0 from E until E+1.
- With `out_ready` held high, lanes 0..N-1 appear on N consecutive cycles.
- `acc_clear` is high on the cycle after the last beat.
- `busy` is high from edge E until the end of the CLR cycle.
- The earliest accepted next `done` is the cycle after CLR, i.e. N+2 cycles after E.
- `out_valid` never drops while idx<N-1 without a beat.
- Consumer may hold `out_ready` high or low arbitrarily; `out_ready` has no effect outside SEND.

## Configuration
- `DRAIN_AUTOCLEAR_EN` defined:
  - CLR state exists.
  - `acc_clear` pulses as described above.
- `DRAIN_AUTOCLEAR_EN` undefined:
  - No CLR state; the last beat in SEND goes directly to IDLE.
  - `acc_clear` is tied to 0.
  - `busy` drops one cycle earlier.
  - A next `done` is accepted N+1 cycles after E.

## Test plan
- Basic drain, N=4, W=8, macro defined:
  - Stimulus: `acc_bus`={8'd40,8'd30,8'd20,8'd10}, `done` pulse, `out_ready`=1.
  - Response: `out_data` 10,20,30,40 with `out_idx` 0..3 on 4 consecutive cycles; then `acc_clear`=1 for one cycle; then `busy`=0.
- Backpressure:
  - Stimulus: same data, `out_ready`=0 for 3 cycles while idx=1.
  - Response: `out_data`=20, `out_idx`=1, `out_valid`=1 held stable; sequence resumes 30, 40 once ready returns.
- Snapshot isolation:
  - Stimulus: change `acc_bus` to all 8'hFF one cycle after `done`.
  - Response: drained values remain 10,20,30,40.
- Overrun:
  - Stimulus: second `done` during SEND at idx=2.
  - Response: `overrun`=1 and stays 1; drain completes unchanged with exactly one `acc_clear` pulse.
- Reset mid-drain:
  - Stimulus: assert `clear` between clock edges at idx=2.
  - Response: all outputs become 0 immediately, without waiting for a clock edge; no `acc_clear`; a new `done` afterwards drains starting from lane 0.
- Macro undefined:
  - Stimulus: basic drain.
  - Response: same 4 beats; `acc_clear` never asserts; `busy`=0 on the cycle after the last beat.

Source files
------------

// File: rtl/systolic_result_drain_if.sv
// Result stream from the systolic drain: one accumulator lane per beat, valid/ready handshake.
interface systolic_result_drain_if #(
  parameter int W  = 8,
  parameter int IW = 2
);
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_idx;
  logic          out_valid;
  logic          out_ready;

  modport master (output out_data, output out_idx, output out_valid, input out_ready);
  modport slave  (input out_data, input out_idx, input out_valid, output out_ready);
endinterface

// File: rtl/systolic_result_drain.sv
// Snapshots N accumulator lanes on done and streams them out one per beat (lane 0 valid the cycle after done, stalls hold on !out_ready).
// DRAIN_AUTOCLEAR_EN adds a CLR state that pulses acc_clear once after the last beat.
module systolic_result_drain #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     done,
  input  logic [N*W-1:0]           acc_bus,
  systolic_result_drain_if.master  out,
  output logic                     acc_clear,
  output logic                     busy,
  output logic                     overrun
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
`ifdef DRAIN_AUTOCLEAR_EN
  localparam logic [1:0] CLR  = 2'd2;
  logic                  clr_q;
`endif

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [W-1:0]  snap [N];
  logic [W-1:0]  data_q;
  logic          vld_q;
  logic          ovr_q;
  logic          beat;
  logic          last;

  assign beat    = vld_q && out.out_ready;
  assign last    = (idx == IW'(N - 1));
  assign idx_nxt = idx + IW'(1);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state  <= IDLE;
      idx    <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
      for (int k = 0; k < N; k++) snap[k] <= '0;
`ifdef DRAIN_AUTOCLEAR_EN
      clr_q  <= 1'b0;
`endif
    end else begin
`ifdef DRAIN_AUTOCLEAR_EN
      clr_q <= 1'b0;
`endif
      // A done that cannot be honoured leaves the drain untouched but is remembered.
      if (done && (state != IDLE)) ovr_q <= 1'b1;

      case (state)
        IDLE: begin
          if (done) begin
            for (int k = 0; k < N; k++) snap[k] <= acc_bus[k*W +: W];
            idx    <= '0;
            data_q <= acc_bus[W-1:0];
            vld_q  <= 1'b1;
            state  <= SEND;
          end
        end
        SEND: begin
          if (beat) begin
            if (!last) begin
              idx    <= idx_nxt;
              data_q <= snap[idx_nxt];
            end else begin
              vld_q <= 1'b0;
`ifdef DRAIN_AUTOCLEAR_EN
              clr_q <= 1'b1;
              state <= CLR;
`else
              state <= IDLE;
`endif
            end
          end
        end
`ifdef DRAIN_AUTOCLEAR_EN
        CLR: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign out.out_data  = data_q;
  assign out.out_idx   = idx;
  assign out.out_valid = vld_q;
  assign busy          = (state != IDLE);
  assign overrun       = ovr_q;
`ifdef DRAIN_AUTOCLEAR_EN
  assign acc_clear     = clr_q;
`else
  assign acc_clear     = 1'b0;
`endif
endmodule
